// File: rtl/uart_tx_arb.sv
// uart_tx_arb
//   Round-robin arbiter sharing one uart_tx between four byte producers.
//   uart_tx has no busy output, so each frame (10 bits plus GAP_BITS idle
//   bits) is timed here before the next grant is allowed.
//
// Ports
//   sys_clk   in   system clock, rising edge
//   sys_rst   in   asynchronous active-high reset
//   req       in   [3:0]  per-requester request level
//   req_data  in   [31:0] requester i byte at [8i+7:8i]
//   ack       out  [3:0]  one-cycle accept pulse to the granted requester
//   po_data   out  [7:0]  byte to uart_tx pi_data
//   po_flag   out         one-cycle load strobe to uart_tx pi_flag
//   busy      out         high whenever not IDLE
//   grant_id  out  [1:0]  index of the last granted requester
module uart_tx_arb #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int UART_BPS = 9600,
  parameter int GAP_BITS = 1
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  ack,
  output logic [7:0]  po_data,
  output logic        po_flag,
  output logic        busy,
  output logic [1:0]  grant_id
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int FRAME_CYCLES = BAUD_CNT_MAX * (10 + GAP_BITS);
  localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [7:0]         r_po_data;
  logic [1:0]         r_grant_id;
  logic               w_found;
  logic [1:0]         w_sel;
  logic               w_cnt_tc;

  assign w_cnt_tc = (r_cnt == CNT_W'(FRAME_CYCLES - 1));

  // Search starts one past the last grant and ends on the last grant
  // itself, so a lone continuous requester still gets re-granted.
  always_comb begin
    logic [1:0] w_idx;
    w_found = 1'b0;
    w_sel   = r_grant_id;
    w_idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_idx = r_grant_id + 2'(k);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    po_flag     = 1'b0;
    ack         = '0;
    busy        = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_found) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        po_flag          = 1'b1;
        ack[r_grant_id]  = 1'b1;
        w_state_nxt      = S_WAIT;
      end
      S_WAIT: begin
        if (w_cnt_tc) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_po_data  <= '0;
      r_grant_id <= 2'd3;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_WAIT && !w_cnt_tc) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
      if (r_state == S_IDLE && w_found) begin
        r_po_data  <= req_data[{w_sel, 3'b000} +: 8];
        r_grant_id <= w_sel;
      end
    end
  end

  assign po_data  = r_po_data;
  assign grant_id = r_grant_id;

endmodule
